// File: rtl/switch_debouncer.sv
// Switch conditioner: 2-flop synchronizer plus a per-bit debounce counter.
// Produces the stable switch vector, per-bit edge pulses and a clearable change flag.
module switch_debouncer #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] switches,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    input  logic            clr_changed,
    output logic            changed_sticky
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  r_sync1;
    logic [N_SW-1:0]  r_sync2;
    logic [CNT_W-1:0] r_cnt [N_SW];
    logic [N_SW-1:0]  r_switches;
    logic [N_SW-1:0]  r_rise;
    logic [N_SW-1:0]  r_fall;
    logic             r_changed;
    logic [N_SW-1:0]  w_mismatch;
    logic [N_SW-1:0]  w_update;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Counter holds the number of consecutive mismatched cycles seen so far;
    // the stable bit flips on the cycle the count would reach DEBOUNCE_CYCLES.
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
        assign w_mismatch[gi] = r_sync2[gi] ^ r_switches[gi];
        assign w_update[gi]   = w_mismatch[gi] && (r_cnt[gi] == CNT_LAST);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt[gi] <= '0;
            end else if (!w_mismatch[gi] || w_update[gi]) begin
                r_cnt[gi] <= '0;
            end else begin
                r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_switches <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_changed  <= 1'b0;
        end else begin
            r_switches <= r_switches ^ w_update;
            r_rise     <= w_update & r_sync2;
            r_fall     <= w_update & ~r_sync2;
            // A transition on this edge wins over a simultaneous clear.
            r_changed  <= (r_changed & ~clr_changed) | (|w_update);
        end
    end

    assign switches       = r_switches;
    assign sw_rise        = r_rise;
    assign sw_fall        = r_fall;
    assign changed_sticky = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with DEBOUNCE_CYCLES=4: stimulus queues
// expected output snapshots keyed by clock edge; a monitor pops and compares them.
module tb_switch_debouncer;

    localparam int N_SW = 10;
    localparam int DB   = 4;

    typedef struct {
        int             cyc;
        logic [N_SW-1:0] sw;
        logic [N_SW-1:0] rise;
        logic [N_SW-1:0] fall;
        logic            ch;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_SW-1:0] sw_raw = '0;
    logic            clr_changed = 1'b0;
    logic [N_SW-1:0] switches;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            changed_sticky;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   pulse_bits = 0;
    int   exp_pulse_bits = 0;
    exp_t exp_q[$];

    switch_debouncer #(.N_SW(N_SW), .DEBOUNCE_CYCLES(DB)) dut (
        .clk            (clk),
        .reset          (reset),
        .sw_raw         (sw_raw),
        .switches       (switches),
        .sw_rise        (sw_rise),
        .sw_fall        (sw_fall),
        .clr_changed    (clr_changed),
        .changed_sticky (changed_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [N_SW-1:0] sw, input logic [N_SW-1:0] rise,
                        input logic [N_SW-1:0] fall, input logic ch);
        exp_t e;
        e.cyc = c; e.sw = sw; e.rise = rise; e.fall = fall; e.ch = ch;
        exp_q.push_back(e);
        exp_pulse_bits += $countones(rise) + $countones(fall);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new steady level and expect the update six edges later.
    task automatic change(input logic [N_SW-1:0] val, input logic [N_SW-1:0] old_sw,
                          input logic [N_SW-1:0] rise, input logic [N_SW-1:0] fall,
                          input logic ch_before);
        int k;
        k = cyc;
        sw_raw = val;
        push(k + 5, old_sw, '0, '0, ch_before);
        push(k + 6, val, rise, fall, 1'b1);
        push(k + 7, val, '0, '0, 1'b1);
        step(7);
    endtask

    // Monitor: compare queued snapshots at the matching edge, tally pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if ((sw_rise & sw_fall) != '0) begin
                failures++;
                $display("FAIL rise_fall_overlap cyc=%0d rise=%h fall=%h required no common bit",
                         cyc, sw_rise, sw_fall);
            end
            pulse_bits += $countones(sw_rise) + $countones(sw_fall);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    failures++;
                    $display("FAIL missed_sample got cyc=%0d required cyc=%0d", cyc, e.cyc);
                end else if (switches !== e.sw || sw_rise !== e.rise || sw_fall !== e.fall ||
                             changed_sticky !== e.ch) begin
                    failures++;
                    $display("FAIL snapshot cyc=%0d got sw=%h rise=%h fall=%h ch=%b required sw=%h rise=%h fall=%h ch=%b",
                             cyc, switches, sw_rise, sw_fall, changed_sticky,
                             e.sw, e.rise, e.fall, e.ch);
                end else begin
                    $display("cyc=%0d sw=%h rise=%h fall=%h ch=%b ok",
                             cyc, switches, sw_rise, sw_fall, changed_sticky);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset held for edges 1..3, then 20 idle cycles with all outputs low.
        for (int i = 1; i <= 3; i++) push(i, '0, '0, '0, 1'b0);
        step(3);
        reset = 1'b0;
        for (int i = 4; i <= 23; i++) push(i, '0, '0, '0, 1'b0);
        step(20);

        // Clean rise on bit 0.
        change(10'h001, 10'h000, 10'h001, 10'h000, 1'b0);

        // Clear with no transition pending.
        k = cyc;
        clr_changed = 1'b1;
        push(k + 1, 10'h001, '0, '0, 1'b0);
        push(k + 2, 10'h001, '0, '0, 1'b0);
        step(1);
        clr_changed = 1'b0;
        step(1);

        // Bit 3 bounces: 3-cycle highs separated by 2-cycle lows never pass.
        k = cyc;
        for (int i = 1; i <= 14; i++) push(k + i, 10'h001, '0, '0, 1'b0);
        sw_raw = 10'h009; step(3);
        sw_raw = 10'h001; step(2);
        sw_raw = 10'h009; step(3);
        sw_raw = 10'h001; step(2);
        change(10'h009, 10'h001, 10'h008, 10'h000, 1'b0);

        // All high, then multi-bit fall to 0x155.
        change(10'h3FF, 10'h009, 10'h3F6, 10'h000, 1'b1);
        change(10'h155, 10'h3FF, 10'h000, 10'h2AA, 1'b1);

        // Clear asserted across the edge before and the edge of a transition.
        k = cyc;
        sw_raw = 10'h000;
        push(k + 5, 10'h155, '0, '0, 1'b0);
        push(k + 6, 10'h000, '0, 10'h155, 1'b1);
        push(k + 7, 10'h000, '0, '0, 1'b1);
        step(4);
        clr_changed = 1'b1;
        step(2);
        clr_changed = 1'b0;
        step(1);

        // Reset while bit 9 has counted to 2; debounce restarts afterwards.
        k = cyc;
        sw_raw = 10'h200;
        for (int i = 1; i <= 4; i++) push(k + i, 10'h000, '0, '0, 1'b1);
        for (int i = 5; i <= 10; i++) push(k + i, 10'h000, '0, '0, 1'b0);
        push(k + 11, 10'h200, 10'h200, '0, 1'b1);
        push(k + 12, 10'h200, '0, '0, 1'b1);
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(9);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
        end
        checks++;
        if (pulse_bits != exp_pulse_bits) begin
            failures++;
            $display("FAIL pulse_total got %0d required %0d", pulse_bits, exp_pulse_bits);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
